// File: rtl/i2s_pkg.sv
// Shared I2S frame geometry: 64 sclk per frame, two 32-bit channel slots.
package i2s_pkg;
  localparam int CH_BITS    = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [$clog2(FRAME_BITS)-1:0] bit_cnt_t;

  localparam bit_cnt_t LRCK_RISE = 6'd31;
  localparam bit_cnt_t LRCK_FALL = 6'd63;
  localparam bit_cnt_t LAST_BIT  = bit_cnt_t'(FRAME_BITS - 1);
endpackage

// File: rtl/i2s_tx_tmg.sv
// Bit/word clock generator: div_cnt divides clk into sclk, bit_cnt walks the 64-bit frame.
// sclk/lrck are registered from next-state counts so they line up exactly with div_cnt/bit_cnt.
module i2s_tx_tmg #(
  parameter int SCLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sclk,
  output logic       lrck,
  output logic [5:0] bit_cnt,
  output logic       fall,
  output logic       ld
);
  import i2s_pkg::*;

  localparam int DIV_W = $clog2(2 * SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  bit_cnt_t         bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             lrck_q, lrck_d;
  logic             div_wrap;

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    if (div_wrap) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
    end
    sclk_d = (div_cnt_d >= DIV_HALF);
    // lrck leads the MSB of each channel by one sclk
    lrck_d = (bit_cnt_d >= LRCK_RISE) && (bit_cnt_d != LRCK_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      lrck_q    <= lrck_d;
    end
  end

  assign sclk    = sclk_q;
  assign lrck    = lrck_q;
  assign bit_cnt = bit_cnt_q;
  assign fall    = (div_cnt_q == '0);
  assign ld      = div_wrap && (bit_cnt_q == LAST_BIT);
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one pending + one held sample, same sample on both channels.
// A sample accepted before ld has its MSB on sdout at the sclk fall right after ld; no backpressure, flags urun/orun.
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SCLK_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  sclk,
  output logic                  lrck,
  output logic                  sdout,
  output logic                  frm_o,
  output logic                  urun_o,
  output logic                  orun_o
);
  import i2s_pkg::*;

  logic [5:0]            bit_cnt;
  logic                  fall;
  logic                  ld;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic                  pend_full_q, pend_full_d;
  logic                  sdout_q, sdout_d;
  logic                  frm_q, frm_d;
  logic                  urun_q, urun_d;
  logic                  orun_q, orun_d;
  logic [CH_BITS-1:0]    ch_word;
  logic [2*CH_BITS-1:0]  frame_word;

  i2s_tx_tmg #(.SCLK_DIV(SCLK_DIV)) u_tmg (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .lrck    (lrck),
    .bit_cnt (bit_cnt),
    .fall    (fall),
    .ld      (ld)
  );

  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    held_d      = held_q;
    frm_d       = 1'b0;
    urun_d      = 1'b0;
    orun_d      = 1'b0;
    if (ld) begin
      if (pend_full_q) begin
        held_d = pend_q;
        frm_d  = 1'b1;
        if (vld_i) begin
          pend_d = data_i;
        end else begin
          pend_full_d = 1'b0;
        end
      end else if (vld_i) begin
        // sample arriving exactly at ld goes straight to the wire
        held_d = data_i;
        frm_d  = 1'b1;
      end else begin
        urun_d = 1'b1;
      end
    end else if (vld_i) begin
      pend_d      = data_i;
      pend_full_d = 1'b1;
      orun_d      = pend_full_q;
    end

    // Left-justify the sample in each 32-bit slot; ~bit_cnt maps bit 0 to the MSB
    ch_word = '0;
    ch_word[CH_BITS-1 -: DATA_WIDTH] = held_q;
    frame_word = {ch_word, ch_word};
    sdout_d = fall ? frame_word[~bit_cnt] : sdout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      held_q      <= '0;
      sdout_q     <= 1'b0;
      frm_q       <= 1'b0;
      urun_q      <= 1'b0;
      orun_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      held_q      <= held_d;
      sdout_q     <= sdout_d;
      frm_q       <= frm_d;
      urun_q      <= urun_d;
      orun_q      <= orun_d;
    end
  end

  assign sdout  = sdout_d;
  assign frm_o  = frm_q;
  assign urun_o = urun_q;
  assign orun_o = orun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (SCLK_DIV=2, 24-bit): per-frame expectations queued by stimulus,
// checked by a DAC-style monitor that samples sdout on sclk rising edges.
module tb_i2s_tx;
  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        vld_i  = 1'b0;
  logic [23:0] data_i = 24'h0;
  logic        sclk, lrck, sdout, frm_o, urun_o, orun_o;

  always #5 clk = ~clk;

  i2s_tx #(.DATA_WIDTH(24), .SCLK_DIV(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .vld_i  (vld_i),
    .sclk   (sclk),
    .lrck   (lrck),
    .sdout  (sdout),
    .frm_o  (frm_o),
    .urun_o (urun_o),
    .orun_o (orun_o)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int tcyc   = 0;
  bit mon_en = 1'b0;

  // Reference timebase: clk cycles since the last reset edge
  always @(posedge clk) tcyc <= rst ? 0 : tcyc + 1;

  typedef struct {
    logic [23:0] smp;
    int          frm;
    int          urun;
    int          orun;
  } rec_t;
  rec_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [23:0] smp, input int f, input int u, input int o);
    rec_t r;
    r.smp = smp; r.frm = f; r.urun = u; r.orun = o;
    exp_q.push_back(r);
  endtask

  // ---------------- monitor ----------------
  logic [63:0] cap       = '0;
  logic        sclk_prev = 1'b0;
  int          c_frm = 0, c_urun = 0, c_orun = 0, nfr = 0;

  always @(negedge clk) begin
    int          bitn;
    rec_t        r;
    logic [23:0] left, right;
    logic        pad;
    if (mon_en) begin
      bitn = (tcyc / 4) % 64;
      chk("sclk", 32'(sclk), 32'((tcyc % 4) >= 2));
      chk("lrck", 32'(lrck), 32'(bitn >= 31 && bitn <= 62));
      if (tcyc % 256 == 0) begin
        c_frm = 0; c_urun = 0; c_orun = 0;
      end
      c_frm  += int'(frm_o);
      c_urun += int'(urun_o);
      c_orun += int'(orun_o);
      if (sclk && !sclk_prev) cap[bitn] = sdout;
      sclk_prev = sclk;
      if (tcyc % 256 == 255) begin
        for (int i = 0; i < 24; i++) begin
          left[23-i]  = cap[i];
          right[23-i] = cap[32+i];
        end
        pad = (|cap[31:24]) | (|cap[63:56]);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame%0d: got a frame, expected none queued", nfr);
        end else begin
          r = exp_q.pop_front();
          chk($sformatf("frame%0d_left", nfr),  32'(left),   32'(r.smp));
          chk($sformatf("frame%0d_right", nfr), 32'(right),  32'(r.smp));
          chk($sformatf("frame%0d_pad", nfr),   32'(pad),    32'(0));
          chk($sformatf("frame%0d_frm", nfr),   32'(c_frm),  32'(r.frm));
          chk($sformatf("frame%0d_urun", nfr),  32'(c_urun), 32'(r.urun));
          chk($sformatf("frame%0d_orun", nfr),  32'(c_orun), 32'(r.orun));
        end
        nfr++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic wait_until(input int c);
    int g = 0;
    while (tcyc != c) begin
      @(negedge clk);
      g++;
      if (g > 20000) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_until: timebase stuck at %0d, expected to reach %0d", tcyc, c);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic send(input int c, input logic [23:0] d);
    wait_until(c);
    data_i = d;
    vld_i  = 1'b1;
    @(negedge clk);
    vld_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sclk"},  32'(sclk),   32'(0));
    chk({tag, "_lrck"},  32'(lrck),   32'(0));
    chk({tag, "_sdout"}, 32'(sdout),  32'(0));
    chk({tag, "_frm"},   32'(frm_o),  32'(0));
    chk({tag, "_urun"},  32'(urun_o), 32'(0));
    chk({tag, "_orun"},  32'(orun_o), 32'(0));
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // first frame is silent; A5C3F1 accepted mid-frame goes out in frame 1
    push(24'h000000, 0, 0, 0);
    push(24'hA5C3F1, 1, 0, 0);
    send(100, 24'hA5C3F1);

    // underrun: 123456 repeats for two more frames
    push(24'h123456, 1, 0, 0);
    push(24'h123456, 0, 1, 0);
    push(24'h123456, 0, 1, 1);
    send(256 + 100, 24'h123456);

    // overrun in frame 4: 222222 wins
    push(24'h222222, 1, 0, 0);
    send(4*256 + 50,  24'h111111);
    send(4*256 + 120, 24'h222222);

    // collision, pending empty: bypass into held
    push(24'h0F0F0F, 1, 0, 0);
    send(5*256 + 255, 24'h0F0F0F);

    // collision, pending full: 777777 now, 0F0F0F next
    push(24'h777777, 1, 0, 0);
    push(24'h0F0F0F, 1, 0, 0);
    send(6*256 + 100, 24'h777777);
    send(6*256 + 255, 24'h0F0F0F);

    // frame 9 carries FFFFFF and is aborted at bit 10 with 0ABCDE pending
    send(8*256 + 100, 24'hFFFFFF);
    send(9*256 + 20,  24'h0ABCDE);
    wait_until(9*256 + 41);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    push(24'h000000, 0, 0, 0);
    push(24'h000000, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    chk("frames_seen", 32'(nfr), 32'(11));
    finish_run();
  end
endmodule
